cmd_arb: RTL

CMD_ARB -- requirements
Module: cmd_arb

---
 rtl/cmd_arb_pkg.sv | 15 +
 rtl/cmd_arb.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cmd_arb_pkg.sv
// Shared definitions for the two-requester command arbiter: FSM states,
// the timeout response tag and the requester count.
package cmd_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD_CMD = 2'd1,
    S_EXE    = 2'd2,
    S_WR_RSP = 2'd3
  } state_e;

  localparam logic [15:0] TMO_TAG = 16'hDEAD;
  localparam int          NUM_REQ = 2;

endpackage

// File: rtl/cmd_arb.sv
// Round-robin arbiter that hands one command at a time from two requester
// FIFOs to a shared executor and routes the response (or a timeout tag) back.
import cmd_arb_pkg::*;

module cmd_arb #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cmd0_data,
  input  logic        cmd0_waitreq,
  output logic        cmd0_rdreq,
  input  logic [31:0] cmd1_data,
  input  logic        cmd1_waitreq,
  output logic        cmd1_rdreq,
  output logic [31:0] rsp0_data,
  output logic        rsp0_wrreq,
  input  logic        rsp0_waitreq,
  output logic [31:0] rsp1_data,
  output logic        rsp1_wrreq,
  input  logic        rsp1_waitreq,
  output logic [31:0] exe_cmd,
  output logic        exe_run,
  input  logic [31:0] exe_rsp,
  input  logic        exe_done,
  output logic        grant,
  output logic        busy,
  output logic [7:0]  tmo_cnt
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        grant_q;
  logic        lastGrant_q;
  logic [31:0] exeCmd_q;
  logic [31:0] rsp_q;
  logic [15:0] tmr_q;
  logic [7:0]  tmoCnt_q;

  logic [NUM_REQ-1:0] pending;
  logic               pick;
  logic               tmoHit;
  logic               rspWait;

  assign pending = {~cmd1_waitreq, ~cmd0_waitreq};
  assign tmoHit  = (tmr_q == TMO_LAST);
  assign rspWait = grant_q ? rsp1_waitreq : rsp0_waitreq;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    pick = 1'b0;
    if (&pending) pick = ~lastGrant_q;
    else          pick = pending[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (|pending)             state_d = S_RD_CMD;
      S_RD_CMD:                           state_d = S_EXE;
      S_EXE:    if (exe_done || tmoHit)   state_d = S_WR_RSP;
      S_WR_RSP: if (!rspWait)             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    exe_run    = (state_q == S_EXE);
    cmd0_rdreq = (state_q == S_RD_CMD) && !grant_q;
    cmd1_rdreq = (state_q == S_RD_CMD) &&  grant_q;
    rsp0_wrreq = (state_q == S_WR_RSP) && !grant_q && !rsp0_waitreq;
    rsp1_wrreq = (state_q == S_WR_RSP) &&  grant_q && !rsp1_waitreq;
    rsp0_data  = grant_q ? 32'h0 : rsp_q;
    rsp1_data  = grant_q ? rsp_q : 32'h0;
  end

  // Done takes priority over a timeout landing on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      exeCmd_q    <= '0;
      rsp_q       <= '0;
      tmr_q       <= '0;
      tmoCnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|pending) begin
            grant_q     <= pick;
            lastGrant_q <= pick;
          end
        end
        S_RD_CMD: begin
          exeCmd_q <= grant_q ? cmd1_data : cmd0_data;
          tmr_q    <= '0;
        end
        S_EXE: begin
          if (exe_done) begin
            rsp_q <= exe_rsp;
          end else if (tmoHit) begin
            rsp_q <= {TMO_TAG, exeCmd_q[15:0]};
            if (tmoCnt_q != 8'hFF) tmoCnt_q <= tmoCnt_q + 8'd1;
          end else begin
            tmr_q <= tmr_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign exe_cmd = exeCmd_q;
  assign grant   = grant_q;
  assign tmo_cnt = tmoCnt_q;

endmodule
